// File: rtl/intc_reg_bank.sv
// intc_reg_bank: APB register bank for the interrupt controller (INTCR/IER/ISR/ISCR/IPR) with sense detection.
module intc_reg_bank #(
  parameter int NUM_IRQ = 16,
  parameter int NUM_IPR = 14,
  parameter int ADDR_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic [31:0]            pwdata,
  input  logic [3:0]             pstrb,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic [NUM_IRQ-1:0]     irq_pending,
  output logic [2:0]             intcr,
  output logic [2*NUM_IRQ-1:0]   iscr,
  output logic [12*NUM_IPR-1:0]  ipr_flat
);
  localparam int NISCR = (NUM_IRQ + 15) / 16;

  logic [NUM_IRQ-1:0]   s1_q, s2_q, p_q, ier_q, ier_d, isr_q, isr_d, evt, clr;
  logic [2*NUM_IRQ-1:0] iscr_q, iscr_d;
  logic [63:0]          iscr_w, iscr_nw;
  logic [11:0]          ipr_q [NUM_IPR];
  logic [11:0]          ipr_d [NUM_IPR];
  logic [11:0]          ipr_v [16];
  logic [2:0]           intcr_q, intcr_d;
  logic [31:0]          wa, bm, wv, cur, nw, prdata_q, prdata_d;
  logic [3:0]           ipr_k;
  logic                 acc, wr, rd_first, rd_ph_q, rd_ph_d, mapped;
  logic                 is_intcr, is_ier, is_isr, is_iscr, is_ipr;
  logic                 unused;

  function automatic logic [31:0] exp12(input logic [11:0] x);
    return {17'b0, x[11:9], 1'b0, x[8:6], 1'b0, x[5:3], 1'b0, x[2:0]};
  endfunction

  function automatic logic [11:0] cmp12(input logic [31:0] w);
    return {w[14:12], w[10:8], w[6:4], w[2:0]};
  endfunction

  assign wa       = 32'(paddr[ADDR_W-1:2]);
  assign ipr_k    = wa[3:0];
  assign is_intcr = wa == 32'd0;
  assign is_ier   = wa == 32'd2;
  assign is_isr   = wa == 32'd3;
  assign is_iscr  = wa >= 32'd4 && wa < 32'(4 + NISCR);
  assign is_ipr   = wa >= 32'd16 && wa < 32'(16 + NUM_IPR);
  assign mapped   = is_intcr | is_ier | is_isr | is_iscr | is_ipr;
  assign acc      = psel & penable;
  assign wr       = acc & pwrite & mapped;
  assign rd_first = acc & ~pwrite & ~rd_ph_q;
  assign rd_ph_d  = rd_first;
  assign bm       = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
  assign wv       = pwdata & bm;
  assign iscr_w   = 64'(iscr_q);
  assign unused   = ^{paddr[1:0], iscr_nw};

  // Writes complete immediately; reads complete one cycle after the data capture.
  assign pready      = ~rst & acc & (pwrite | rd_ph_q);
  assign pslverr     = pready & ~mapped;
  assign prdata      = prdata_q;
  assign irq_pending = isr_q & ier_q;
  assign intcr       = intcr_q;
  assign iscr        = iscr_q;

  for (genvar k = 0; k < 16; k++) begin : g_ipr
    if (k < NUM_IPR) begin : g_on
      assign ipr_v[k]             = ipr_q[k];
      assign ipr_flat[12*k +: 12] = ipr_q[k];
    end else begin : g_off
      assign ipr_v[k] = '0;
    end
  end

  always_comb begin
    cur      = is_intcr ? {26'b0, intcr_q, 3'b0} :
               is_ier   ? 32'(ier_q) :
               is_isr   ? 32'(isr_q) :
               is_iscr  ? (wa[0] ? iscr_w[63:32] : iscr_w[31:0]) :
               is_ipr   ? exp12(ipr_v[ipr_k]) : '0;
    nw       = (cur & ~bm) | wv;
    intcr_d  = (wr && is_intcr) ? nw[5:3] : intcr_q;
    ier_d    = (wr && is_ier) ? NUM_IRQ'(nw) : ier_q;
    iscr_nw  = wa[0] ? {nw, iscr_w[31:0]} : {iscr_w[63:32], nw};
    iscr_d   = (wr && is_iscr) ? iscr_nw[2*NUM_IRQ-1:0] : iscr_q;
    clr      = (wr && is_isr) ? NUM_IRQ'(wv) : '0;
    prdata_d = rd_first ? cur : prdata_q;
    evt      = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      evt[i] = iscr_q[2*i+1] ? (iscr_q[2*i] ? p_q[i] ^ s2_q[i] : ~p_q[i] & s2_q[i])
                             : (iscr_q[2*i] ? p_q[i] & ~s2_q[i] : ~s2_q[i]);
    // A same-cycle event overrides the write-1-to-clear.
    isr_d    = (isr_q & ~clr) | evt;
    for (int k = 0; k < NUM_IPR; k++)
      ipr_d[k] = (wr && is_ipr && ipr_k == 4'(k)) ? cmp12(nw) : ipr_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '1;
      s2_q     <= '1;
      p_q      <= '1;
      ier_q    <= '0;
      isr_q    <= '0;
      iscr_q   <= '0;
      intcr_q  <= '0;
      prdata_q <= '0;
      rd_ph_q  <= 1'b0;
      for (int k = 0; k < NUM_IPR; k++) ipr_q[k] <= '0;
    end else begin
      s1_q     <= irq_in;
      s2_q     <= s1_q;
      p_q      <= s2_q;
      ier_q    <= ier_d;
      isr_q    <= isr_d;
      iscr_q   <= iscr_d;
      intcr_q  <= intcr_d;
      prdata_q <= prdata_d;
      rd_ph_q  <= rd_ph_d;
      for (int k = 0; k < NUM_IPR; k++) ipr_q[k] <= ipr_d[k];
    end
  end
endmodule
